whirlpool_round_ctrl: RTL and testbench

- Iterative Whirlpool compression engine: out = W_H(m) ^ H ^ m (Miyaguchi-Preneel), one 512-bit block per job.
- Owns a single shared round datapath of 8 process_row instances; time-multiplexes it between the key schedule and the cipher state, alternating KEY and STATE cycles over 10 rounds.
- Sits between the miner's nonce/message scheduler (upstream) and the hash-compare stage (downstream); ready/valid on both sides.

---
 rtl/whirlpool_pkg.sv | 33 +++
 rtl/whirlpool_rho.sv | 36 +++
 rtl/whirlpool_round_ctrl.sv | 74 +++++++
 tb/tb_whirlpool_round_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/whirlpool_pkg.sv
// whirlpool_pkg: shared widths, state encoding, round constants and S-box/GF helpers for the Whirlpool engine
package whirlpool_pkg;
  localparam int ROW_W = 64;
  localparam int BLK_W = 512;
  typedef enum logic [2:0] {IDLE, KEY, STATE, FINAL, DONE} state_t;
  localparam logic [1:10][ROW_W-1:0] RC = {
    64'h1823c6e887b8014f, 64'h36a6d2f5796f9152, 64'h60bc9b8ea30c7b35, 64'h1de0d7c22e4bfe57,
    64'h157737e59ff04ada, 64'h58c9290ab1a06b85, 64'hbd5d10f4cb3e0567, 64'he427418ba77d95d8,
    64'hfbee7c66dd17479e, 64'hca2dbf07ad5a8333
  };
  // S-box is assembled from the E, E^-1 and R 4-bit mini-boxes
  localparam logic [0:15][3:0] E_BOX  = 64'h1b9cd6f3e874a250;
  localparam logic [0:15][3:0] EI_BOX = 64'hf0d7be5a92c13486;
  localparam logic [0:15][3:0] R_BOX  = 64'h7cbde49f638a2510;
  localparam logic [0:7][3:0] THETA_C = {4'h1, 4'h1, 4'h4, 4'h1, 4'h8, 4'h5, 4'h2, 4'h9};
  function automatic logic [7:0] sbox(input logic [7:0] u);
    logic [3:0] a, b, c;
    a = E_BOX[u[7:4]];
    b = EI_BOX[u[3:0]];
    c = R_BOX[a ^ b];
    return {E_BOX[a ^ c], EI_BOX[b ^ c]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction
endpackage

// File: rtl/whirlpool_rho.sv
// whirlpool_rho: combinational round body (S-box, column shift, row diffusion) over a 512-bit block
module process_row
  import whirlpool_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  output logic [ROW_W-1:0] res
);
  logic [0:7][7:0] g, o;
  always_comb begin
    g = row;
    for (int k = 0; k < 8; k++) g[k] = sbox(g[k]);
    o = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++)
        o[j] = o[j] ^ gf_mul(g[k], THETA_C[3'(j - k)]);
  end
  assign res = o;
endmodule

module whirlpool_rho
  import whirlpool_pkg::*;
(
  input  logic [BLK_W-1:0] x,
  output logic [BLK_W-1:0] y
);
  logic [0:7][0:7][7:0] o, p;
  logic [0:7][ROW_W-1:0] q;
  assign o = x;
  for (genvar i = 0; i < 8; i++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      assign p[i][j] = o[(i - j + 8) % 8][j];
    end
    process_row u_row (.row(p[i]), .res(q[i]));
  end
  assign y = q;
endmodule

// File: rtl/whirlpool_round_ctrl.sv
// whirlpool_round_ctrl: iterative Miyaguchi-Preneel Whirlpool compression sharing one round datapath between key and state
module whirlpool_round_ctrl
  import whirlpool_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_h,
  input  logic [BLK_W-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_hash,
  output logic             busy
);
  state_t state;
  logic [BLK_W-1:0] k, s, hs, ms, rho_in, rho_out;
  logic [3:0] r;
  assign rho_in = state == KEY ? k : s;
  whirlpool_rho u_rho (.x(rho_in), .y(rho_out));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      r <= 4'd1;
      out_hash <= '0;
      k <= '0;
      s <= '0;
      hs <= '0;
      ms <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          k <= in_h;
          s <= in_m ^ in_h;
          hs <= in_h;
          ms <= in_m;
          r <= 4'd1;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= KEY;
        end
        KEY: begin
          k <= rho_out ^ {RC[r], {(BLK_W - ROW_W){1'b0}}};
          state <= STATE;
        end
        STATE: begin
          s <= rho_out ^ k;
          if (r == 4'(ROUNDS)) state <= FINAL;
          else begin
            r <= r + 4'd1;
            state <= KEY;
          end
        end
        FINAL: begin
          out_hash <= s ^ hs ^ ms;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_whirlpool_round_ctrl.sv
// tb_whirlpool_round_ctrl: directed and random checks of the Whirlpool compression engine against a byte-matrix model
module tb_whirlpool_round_ctrl;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready, in_ready, out_valid, busy;
  logic [511:0] in_h, in_m, out_hash;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [511:0] EMPTY_M = {8'h80, 504'h0};
  localparam logic [511:0] EMPTY_D = 512'h19fa61d75522a4669b44e39c1d2e1726c530232130d407f89afee0964997f7a73e83be698b288febcf88e3e03c4f0757ea8964e59b63d93708b138cc42a66eb3;
  int e_t[16] = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
  int ei_t[16] = '{15, 0, 13, 7, 11, 14, 5, 10, 9, 2, 12, 1, 3, 4, 8, 6};
  int r_t[16] = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
  logic [7:0] theta_c[8] = '{8'd1, 8'd1, 8'd4, 8'd1, 8'd8, 8'd5, 8'd2, 8'd9};
  logic [7:0] sb[256];

  whirlpool_round_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_h(in_h), .in_m(in_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    n_chk++;
    assert (dut.r >= 4'd1 && dut.r <= 4'd10) else begin
      n_fail++;
      $error("FAIL round_range observed=%0d expected=1..10", dut.r);
    end
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] byte_at(input logic [511:0] x, input int i, input int j);
    return x[511 - 64 * i - 8 * j -: 8];
  endfunction

  // one full round on an 8x8 byte matrix: substitute, shift column j down by j, mix rows, add key
  function automatic logic [511:0] ref_round(input logic [511:0] x, input logic [511:0] key);
    logic [7:0] a[8][8];
    logic [7:0] acc;
    logic [511:0] y = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        a[i][j] = sb[byte_at(x, (i - j + 8) % 8, j)];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = byte_at(key, i, j);
        for (int q = 0; q < 8; q++) acc = acc ^ gmul(a[i][q], theta_c[(j - q + 8) % 8]);
        y[511 - 64 * i - 8 * j -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [511:0] ref_compress(input logic [511:0] h, input logic [511:0] m);
    logic [511:0] kk, ss, rc;
    kk = h;
    ss = h ^ m;
    for (int rr = 1; rr <= 10; rr++) begin
      rc = '0;
      for (int j = 0; j < 8; j++) rc[511 - 8 * j -: 8] = sb[8 * (rr - 1) + j];
      kk = ref_round(kk, rc);
      ss = ref_round(ss, kk);
    end
    return ss ^ h ^ m;
  endfunction

  // starts at a negedge with the engine idle and ends at a negedge after the output handshake
  task automatic run_job(input logic [511:0] h, input logic [511:0] m, input logic [511:0] exp,
                         input string tag, input bit scramble, input int stall);
    int lat = 0;
    in_h = h;
    in_m = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".in_ready_low"}, in_ready, 1'b0);
    check({tag, ".busy"}, busy, 1'b1);
    in_valid = 1'b0;
    while (!out_valid && lat < 60) begin
      if (scramble) begin
        in_h = rnd512();
        in_m = rnd512();
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 21);
    check({tag, ".hash"}, out_hash, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_h = rnd512();
      in_m = rnd512();
      @(posedge clk);
      @(negedge clk);
      check({tag, ".stall_valid"}, out_valid, 1'b1);
      check({tag, ".stall_hash"}, out_hash, exp);
      check({tag, ".stall_in_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, out_valid, 1'b0);
    check({tag, ".in_ready_back"}, in_ready, 1'b1);
    check({tag, ".hash_kept"}, out_hash, exp);
  endtask

  initial begin
    logic [511:0] ha, ma, hb, mb, got;
    int t_out, t_acc, lat;
    for (int u = 0; u < 256; u++) begin
      int a, b, c;
      a = e_t[u / 16];
      b = ei_t[u % 16];
      c = r_t[a ^ b];
      sb[u] = 8'(e_t[a ^ c] * 16 + ei_t[b ^ c]);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_h = '0;
    in_m = '0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.out_hash", out_hash, '0);
    reset = 1'b0;

    run_job('0, EMPTY_M, EMPTY_D, "kat", 1'b0, 0);

    in_h = '0;
    in_m = EMPTY_M;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midjob.in_ready", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.in_ready", in_ready, 1'b1);
    check("midrst.busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_job('0, EMPTY_M, EMPTY_D, "post_rst", 1'b0, 0);

    run_job('0, EMPTY_M, EMPTY_D, "stall", 1'b0, 5);

    // back-to-back: the accept, 20 round edges, FINAL and the DONE handshake put the next accept 23 edges later
    ha = rnd512();
    ma = rnd512();
    hb = rnd512();
    mb = rnd512();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_h = ha;
    in_m = ma;
    @(posedge clk);
    @(negedge clk);
    in_h = hb;
    in_m = mb;
    t_out = 0;
    t_acc = 0;
    got = '0;
    for (int t = 1; t <= 60 && t_acc == 0; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid && t_out == 0) begin
        t_out = t;
        got = out_hash;
      end
      if (t_out != 0 && busy && !out_valid) t_acc = t;
    end
    in_valid = 1'b0;
    check("b2b.first_latency", t_out, 21);
    check("b2b.first_hash", got, ref_compress(ha, ma));
    check("b2b.accept_gap", t_acc, 23);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("b2b.second_latency", lat, 21);
    check("b2b.second_hash", out_hash, ref_compress(hb, mb));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b.valid_drop", out_valid, 1'b0);

    run_job('0, EMPTY_M, EMPTY_D, "scramble", 1'b1, 0);

    for (int n = 0; n < 200; n++) begin
      ha = rnd512();
      ma = rnd512();
      run_job(ha, ma, ref_compress(ha, ma), $sformatf("rand%0d", n), 1'b0, (n % 25 == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
